input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/calc_pkg.sv | 26 ++
 rtl/debounce_cell.sv | 66 ++++++
 rtl/input_conditioner.sv | 100 ++++++++++
 tb/tb_input_conditioner.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants and button state encoding for the calculator input front end.
package calc_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;
    localparam int SYNC_STAGES             = 2;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_t;

    // A button's state is fully determined by its accepted level and whether a change is pending.
    function automatic btn_state_t btn_state_of(input logic held, input logic pending);
        btn_state_t st;
        case ({held, pending})
            2'b00:   st = RELEASED;
            2'b01:   st = PRESS_WAIT;
            2'b10:   st = PRESSED;
            default: st = RELEASE_WAIT;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// Synchronizer plus debounce counter for one input vector; the whole vector is accepted at once.
module debounce_cell
    import calc_pkg::*;
#(
    parameter int               WIDTH           = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] value,
    output logic             pending,
    output logic             accept
);

    localparam int               CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
        $error("debounce_cell: DEBOUNCE_CYCLES must be at least 2");
    end

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] value_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] incoming;
    logic             changing;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= RESET_VALUE;
        end else begin
            sync_q[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // The sample about to enter the last stage tells us the synchronized value is still moving.
    assign stable   = sync_q[SYNC_STAGES-1];
    assign incoming = sync_q[SYNC_STAGES-2];
    assign changing = (stable != incoming);

    always_comb begin
        pending = (stable != value_q);
        accept  = pending && !changing && (cnt_q == TERM);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            value_q <= RESET_VALUE;
            cnt_q   <= '0;
        end else if (!pending || changing) begin
            cnt_q   <= '0;
        end else if (accept) begin
            value_q <= stable;
            cnt_q   <= '0;
        end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    assign value = value_q;

endmodule

// File: rtl/input_conditioner.sv
// Conditions raw pushbuttons and operand switches into clean levels and one-cycle press events.
module input_conditioner
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_reset_n,
    input  logic       btn_modo_n,
    input  logic       btn_res_n,
    input  logic [3:0] switch_0,
    input  logic [3:0] switch_1,
    output logic       clr_pulse,
    output logic       modo_pulse,
    output logic       res_pulse,
    output logic       clr_held,
    output logic       modo_held,
    output logic       res_held,
    output logic [3:0] num0,
    output logic [3:0] num1
);

    // Index 2 = clear, 1 = mode, 0 = result.
    logic [2:0] btn_raw;
    logic [2:0] btn_value;
    logic [2:0] btn_pending;
    logic [2:0] btn_accept;
    logic [2:0] pulse_q;
    btn_state_t btn_state [3];

    assign btn_raw = {btn_reset_n, btn_modo_n, btn_res_n};

    for (genvar g = 0; g < 3; g++) begin : g_btn
        debounce_cell #(
            .WIDTH           (1),
            .RESET_VALUE     (1'b1),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_cell (
            .clock   (clock),
            .reset   (reset),
            .raw     (btn_raw[g]),
            .value   (btn_value[g]),
            .pending (btn_pending[g]),
            .accept  (btn_accept[g])
        );
    end

    logic num0_pending, num0_accept, num1_pending, num1_accept;
    logic unused_operand_status;

    debounce_cell #(
        .WIDTH           (4),
        .RESET_VALUE     (4'h0),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_num0 (
        .clock   (clock),
        .reset   (reset),
        .raw     (switch_0),
        .value   (num0),
        .pending (num0_pending),
        .accept  (num0_accept)
    );

    debounce_cell #(
        .WIDTH           (4),
        .RESET_VALUE     (4'h0),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_num1 (
        .clock   (clock),
        .reset   (reset),
        .raw     (switch_1),
        .value   (num1),
        .pending (num1_pending),
        .accept  (num1_accept)
    );

    assign unused_operand_status = ^{num0_pending, num0_accept, num1_pending, num1_accept};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            btn_state[i] = btn_state_of(~btn_value[i], btn_pending[i]);
        end
    end

    // Only an accepted press fires; accepting a release leaves the pulse low.
    always_ff @(posedge clock) begin
        if (reset) begin
            pulse_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                pulse_q[i] <= (btn_state[i] == PRESS_WAIT) && btn_accept[i];
            end
        end
    end

    assign {clr_pulse, modo_pulse, res_pulse} = pulse_q;
    assign {clr_held, modo_held, res_held}    = ~btn_value;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with the default debounce length of 4.
module tb_input_conditioner;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       btn_reset_n = 1'b1;
    logic       btn_modo_n  = 1'b1;
    logic       btn_res_n   = 1'b1;
    logic [3:0] switch_0 = 4'h0;
    logic [3:0] switch_1 = 4'h0;
    logic       clr_pulse, modo_pulse, res_pulse;
    logic       clr_held, modo_held, res_held;
    logic [3:0] num0, num1;

    input_conditioner dut (
        .clock       (clock),
        .reset       (reset),
        .btn_reset_n (btn_reset_n),
        .btn_modo_n  (btn_modo_n),
        .btn_res_n   (btn_res_n),
        .switch_0    (switch_0),
        .switch_1    (switch_1),
        .clr_pulse   (clr_pulse),
        .modo_pulse  (modo_pulse),
        .res_pulse   (res_pulse),
        .clr_held    (clr_held),
        .modo_held   (modo_held),
        .res_held    (res_held),
        .num0        (num0),
        .num1        (num1)
    );

    always #5 clock = ~clock;

    // Press-to-pulse delay, counted in edges from the drive point (DEBOUNCE_CYCLES + 2).
    localparam int LAT = 6;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    // Expected pulse cycles per button: 2 = clear, 1 = mode, 0 = result.
    int pulse_q [3][$];

    typedef struct {
        string      name;
        logic [2:0] btn_n;
        logic [3:0] sw0;
        logic [3:0] sw1;
        logic [2:0] pulse_mask;
        logic [2:0] exp_held;
        logic [3:0] exp_num0;
        logic [3:0] exp_num1;
    } vec_t;

    typedef struct {
        string      name;
        logic [2:0] held;
        logic [3:0] n0;
        logic [3:0] n1;
    } lvl_t;

    vec_t vecs [8];
    lvl_t lvl_q [$];

    logic watch_num0 = 1'b0, saw_num0_8 = 1'b0;
    logic watch_modo = 1'b0, saw_modo_held = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic mon_pulse(input int idx, input logic p);
        int e;
        if (p === 1'b1) begin
            tests++;
            if (pulse_q[idx].size() == 0) begin
                failed++;
                $display("FAIL pulse ch%0d: unexpected pulse at cycle %0d, none expected", idx, cyc);
            end else begin
                e = pulse_q[idx].pop_front();
                if (e != cyc) begin
                    failed++;
                    $display("FAIL pulse ch%0d: pulse at cycle %0d expected cycle %0d", idx, cyc, e);
                end
            end
        end
    endtask

    always @(posedge clock) begin
        #1;
        mon_pulse(2, clr_pulse);
        mon_pulse(1, modo_pulse);
        mon_pulse(0, res_pulse);
        if (watch_num0 && num0 === 4'h8) saw_num0_8 = 1'b1;
        if (watch_modo && modo_held !== 1'b0) saw_modo_held = 1'b1;
    end

    function automatic vec_t mk(input string name, input logic [2:0] btn_n, input logic [3:0] sw0,
                                input logic [3:0] sw1, input logic [2:0] mask, input logic [2:0] held,
                                input logic [3:0] n0, input logic [3:0] n1);
        vec_t v;
        v.name = name; v.btn_n = btn_n; v.sw0 = sw0; v.sw1 = sw1;
        v.pulse_mask = mask; v.exp_held = held; v.exp_num0 = n0; v.exp_num1 = n1;
        return v;
    endfunction

    initial begin
        lvl_t e;

        vecs[0] = mk("idle",         3'b111, 4'h0, 4'h0, 3'b000, 3'b000, 4'h0, 4'h0);
        vecs[1] = mk("res_press",    3'b110, 4'h3, 4'h5, 3'b001, 3'b001, 4'h3, 4'h5);
        vecs[2] = mk("modo_plus_res",3'b100, 4'hA, 4'hF, 3'b010, 3'b011, 4'hA, 4'hF);
        vecs[3] = mk("release_all",  3'b111, 4'h0, 4'h0, 3'b000, 3'b000, 4'h0, 4'h0);
        vecs[4] = mk("all_press",    3'b000, 4'hF, 4'h1, 3'b111, 3'b111, 4'hF, 4'h1);
        vecs[5] = mk("clr_only",     3'b011, 4'h6, 4'h9, 3'b000, 3'b100, 4'h6, 4'h9);
        vecs[6] = mk("modo_repress", 3'b001, 4'h6, 4'h9, 3'b010, 3'b110, 4'h6, 4'h9);
        vecs[7] = mk("release_end",  3'b111, 4'h0, 4'h0, 3'b000, 3'b000, 4'h0, 4'h0);

        // Reset for two cycles with everything released.
        tick(2);
        check("reset_pulses", {5'd0, clr_pulse, modo_pulse, res_pulse}, 8'h00);
        check("reset_held",   {5'd0, clr_held, modo_held, res_held}, 8'h00);
        check("reset_num0",   {4'd0, num0}, 8'h00);
        check("reset_num1",   {4'd0, num1}, 8'h00);
        reset = 1'b0;
        tick(1);

        for (int i = 0; i < 8; i++) begin
            {btn_reset_n, btn_modo_n, btn_res_n} = vecs[i].btn_n;
            switch_0 = vecs[i].sw0;
            switch_1 = vecs[i].sw1;
            for (int j = 0; j < 3; j++) begin
                if (vecs[i].pulse_mask[j]) pulse_q[j].push_back(cyc + LAT);
            end
            e.name = vecs[i].name; e.held = vecs[i].exp_held;
            e.n0 = vecs[i].exp_num0; e.n1 = vecs[i].exp_num1;
            lvl_q.push_back(e);
            tick(8);
            e = lvl_q.pop_front();
            check({e.name, "_held"}, {5'd0, clr_held, modo_held, res_held}, {5'd0, e.held});
            check({e.name, "_num0"}, {4'd0, num0}, {4'd0, e.n0});
            check({e.name, "_num1"}, {4'd0, num1}, {4'd0, e.n1});
        end

        // Long result press: held follows the accepted level with the same delay both ways.
        btn_res_n = 1'b0;
        pulse_q[0].push_back(cyc + LAT);
        tick(LAT - 1);
        check("res_held_before", {7'd0, res_held}, 8'h00);
        tick(1);
        check("res_held_after",  {7'd0, res_held}, 8'h01);
        tick(12 - LAT);
        btn_res_n = 1'b1;
        tick(LAT - 1);
        check("res_rel_before",  {7'd0, res_held}, 8'h01);
        tick(1);
        check("res_rel_after",   {7'd0, res_held}, 8'h00);
        tick(4);

        // Mode bounce: 3 low, 1 high, 3 low never reaches acceptance.
        saw_modo_held = 1'b0;
        watch_modo = 1'b1;
        btn_modo_n = 1'b0; tick(3);
        btn_modo_n = 1'b1; tick(1);
        btn_modo_n = 1'b0; tick(3);
        btn_modo_n = 1'b1; tick(8);
        watch_modo = 1'b0;
        check("modo_bounce_held", {7'd0, saw_modo_held}, 8'h00);

        // Operand bounce 8/C before settling on C.
        saw_num0_8 = 1'b0;
        watch_num0 = 1'b1;
        switch_0 = 4'h8; tick(1);
        switch_0 = 4'hC; tick(1);
        switch_0 = 4'h8; tick(1);
        switch_0 = 4'hC;
        tick(LAT - 1);
        check("num0_before", {4'd0, num0}, 8'h00);
        tick(1);
        check("num0_after",  {4'd0, num0}, 8'h0C);
        tick(3);
        watch_num0 = 1'b0;
        check("num0_no_8",   {7'd0, saw_num0_8}, 8'h00);

        // Simultaneous mode and result press.
        btn_modo_n = 1'b0;
        btn_res_n  = 1'b0;
        pulse_q[1].push_back(cyc + LAT);
        pulse_q[0].push_back(cyc + LAT);
        tick(10);
        check("simul_held", {5'd0, clr_held, modo_held, res_held}, 8'h03);
        btn_modo_n = 1'b1;
        btn_res_n  = 1'b1;
        tick(10);

        // Reset while result press is two counts in; full latency from reset release.
        btn_res_n = 1'b0;
        tick(4);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        check("midreset_num0", {4'd0, num0}, 8'h00);
        pulse_q[0].push_back(cyc + LAT);
        tick(LAT - 1);
        check("midreset_held_before", {7'd0, res_held}, 8'h00);
        tick(1);
        check("midreset_held_after",  {7'd0, res_held}, 8'h01);
        tick(3);
        btn_res_n = 1'b1;
        tick(10);

        for (int j = 0; j < 3; j++) begin
            check($sformatf("missing_pulses_ch%0d", j), 8'(pulse_q[j].size()), 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
